// File: rtl/modem_sincos_arbiter.sv
// modem_sincos_arbiter
//   Shares one dual-port sin/cos lookup ROM between NREQ phase requesters.
//   A round-robin arbiter accepts at most one phase per cycle. The ROM is
//   driven from a registered address stage. Each accepted request's ID (and,
//   in quarter-wave mode, its quadrant) rides a LUT_LAT-deep shift register
//   alongside the ROM read. The result is returned registered and ID-tagged.
//   Handshake to o_res_valid latency is LUT_LAT+2 cycles, and one result per
//   cycle is sustained.
//
//   Build option: define MODEM_SINCOS_QUARTER_WAVE_EN when the ROM holds a
//   single quarter-wave sine table (depth 2^(PHASE_W-2)+1). In that mode
//   quadrant folding is applied on the addresses and sign restoration on the
//   data. With the macro undefined, the ROM holds full sin (port A) and cos
//   (port B) tables, and phase is used directly as the address.
//
// Ports
//   i_clk, i_rst_n         clock, async active-low reset
//   i_req_valid/o_req_ready per-requester handshake (ready one-hot or zero)
//   i_req_phase            packed phases, requester k at [k*PHASE_W +: PHASE_W]
//   o_lut_addr_a/b, o_lut_en  ROM address ports and read enable
//   i_lut_a/b              ROM data, LUT_LAT cycles after the address
//   o_res_valid/o_res_id   single-cycle result strobe and owner index
//   o_sin/o_cos            signed results, held while o_res_valid=0
module modem_sincos_arbiter #(
  parameter int NREQ    = 4,
  parameter int PHASE_W = 12,
  parameter int AMP_W   = 16,
  parameter int LUT_LAT = 2,
  parameter int ID_W    = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NREQ-1:0]           i_req_valid,
  output logic [NREQ-1:0]           o_req_ready,
  input  logic [NREQ*PHASE_W-1:0]   i_req_phase,
  output logic [PHASE_W-1:0]        o_lut_addr_a,
  output logic [PHASE_W-1:0]        o_lut_addr_b,
  output logic                      o_lut_en,
  input  logic [AMP_W-1:0]          i_lut_a,
  input  logic [AMP_W-1:0]          i_lut_b,
  output logic                      o_res_valid,
  output logic [ID_W-1:0]           o_res_id,
  output logic [AMP_W-1:0]          o_sin,
  output logic [AMP_W-1:0]          o_cos
);

  logic [NREQ-1:0][PHASE_W-1:0] phase_arr;
  logic [ID_W-1:0]              ptr, lo_id, hi_id, win_id;
  logic                         lo_vld, hi_vld, win_vld, hs;
  logic [NREQ-1:0]              grant;
  logic [PHASE_W-1:0]           win_phase, addr_a_nxt, addr_b_nxt;

  assign phase_arr = i_req_phase;

  // Round-robin: the lowest valid index at or above ptr wins. If there is
  // none, the search wraps and the lowest valid index overall wins.
  always_comb begin
    lo_id  = '0;
    lo_vld = 1'b0;
    hi_id  = '0;
    hi_vld = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        lo_id  = ID_W'(i);
        lo_vld = 1'b1;
      end
      if (i_req_valid[i] && (ID_W'(i) >= ptr)) begin
        hi_id  = ID_W'(i);
        hi_vld = 1'b1;
      end
    end
    win_vld   = lo_vld;
    win_id    = hi_vld ? hi_id : lo_id;
    grant     = '0;
    win_phase = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_vld && (win_id == ID_W'(i))) begin
        grant[i]  = 1'b1;
        win_phase = phase_arr[i];
      end
    end
  end

  // Ready is held low during reset, so nothing is accepted while the
  // pipeline is being cleared.
  assign hs          = win_vld & i_rst_n;
  assign o_req_ready = i_rst_n ? grant : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      ptr <= '0;
    else if (hs)
      ptr <= (win_id == ID_W'(NREQ-1)) ? '0 : win_id + 1'b1;
  end

`ifdef MODEM_SINCOS_QUARTER_WAVE_EN
  // Fold the phase into the first quadrant. Port A reads sin(|r|),
  // port B reads cos(|r|) = sin(Q-r). Odd quadrants swap the roles.
  localparam logic [PHASE_W-1:0] QTR = PHASE_W'(1) << (PHASE_W-2);
  logic [1:0]         win_q;
  logic [PHASE_W-1:0] r_ext, r_cmp;
  logic [LUT_LAT:0][1:0] q_pipe;

  assign win_q      = win_phase[PHASE_W-1 -: 2];
  assign r_ext      = {2'b00, win_phase[PHASE_W-3:0]};
  assign r_cmp      = QTR - r_ext;
  assign addr_a_nxt = win_q[0] ? r_cmp : r_ext;
  assign addr_b_nxt = win_q[0] ? r_ext : r_cmp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_pipe <= '0;
    end else begin
      q_pipe[LUT_LAT:1] <= q_pipe[LUT_LAT-1:0];
      if (hs) q_pipe[0] <= win_q;
    end
  end
`else
  assign addr_a_nxt = win_phase;
  assign addr_b_nxt = win_phase;
`endif

  // Stage 1 drives the ROM. vld_pipe[0] is the read enable. vld_pipe[LUT_LAT]
  // marks the cycle in which the ROM data for that read is present.
  logic [LUT_LAT:0]           vld_pipe;
  logic [LUT_LAT:0][ID_W-1:0] id_pipe;

  assign o_lut_en = vld_pipe[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe     <= '0;
      id_pipe      <= '0;
      o_lut_addr_a <= '0;
      o_lut_addr_b <= '0;
    end else begin
      vld_pipe          <= {vld_pipe[LUT_LAT-1:0], hs};
      id_pipe[LUT_LAT:1] <= id_pipe[LUT_LAT-1:0];
      if (hs) begin
        id_pipe[0]   <= win_id;
        o_lut_addr_a <= addr_a_nxt;
        o_lut_addr_b <= addr_b_nxt;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_res_valid <= 1'b0;
      o_res_id    <= '0;
      o_sin       <= '0;
      o_cos       <= '0;
    end else begin
      o_res_valid <= vld_pipe[LUT_LAT];
      if (vld_pipe[LUT_LAT]) begin
        o_res_id <= id_pipe[LUT_LAT];
`ifdef MODEM_SINCOS_QUARTER_WAVE_EN
        // sin < 0 in quadrants 2,3; cos < 0 in quadrants 1,2.
        o_sin <= q_pipe[LUT_LAT][1] ? -i_lut_a : i_lut_a;
        o_cos <= (q_pipe[LUT_LAT][1] ^ q_pipe[LUT_LAT][0]) ? -i_lut_b : i_lut_b;
`else
        o_sin <= i_lut_a;
        o_cos <= i_lut_b;
`endif
      end
    end
  end

endmodule
